// File: rtl/fft_result_reader_if.sv
// Result-readback bus for fft_result_reader.
// Groups the core result register port (regAddr/regData) and the outgoing
// valid/ready word stream (out_data/out_valid/out_ready/out_last).
// master: the reader. slave: the core plus the stream sink.
interface fft_result_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] regAddr;
    logic [DATA_W-1:0] regData;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output regAddr,
        output out_data,
        output out_valid,
        output out_last,
        input  regData,
        input  out_ready
    );

    modport slave (
        input  regAddr,
        input  out_data,
        input  out_valid,
        input  out_last,
        output regData,
        output out_ready
    );
endinterface

// File: rtl/fft_result_reader.sv
// fft_result_reader: readback sequencer for the RNS Fourier cores.
// Waits for the core's done flag, walks the result register port over
// NUM_WORDS addresses and streams each word on a valid/ready interface with
// a last marker. A cycle watchdog flags a core that never finishes.
//
// Optional build macro RESULT_CHECKSUM_EN adds a modular running sum of the
// accepted beats on the checksum output.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for done; watchdog running
// S_FETCH   | regAddr=idx, word captured into the output register
// S_SEND    | word offered on out_valid until out_ready accepts it
// S_FINISH  | all words delivered, finished held; start re-arms
// S_TIMEOUT | watchdog expired, timeout held; start re-arms
module fft_result_reader #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int NUM_WORDS      = 64,
    parameter int TIMEOUT_CYCLES = 3000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 done,
    fft_result_reader_if.master  bus,
    output logic                 busy,
    output logic                 finished,
    output logic                 timeout
`ifdef RESULT_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]    checksum
`endif
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_SEND    = 3'd2,
        S_FINISH  = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;
    logic              r_finished;
    logic              r_timeout;

    state_t            w_state_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_valid_nxt;
    logic              w_last_nxt;
    logic              w_finished_nxt;
    logic              w_timeout_nxt;

    logic              w_counting;
    logic              w_expire;
    logic              w_accept;
    logic              w_final;

`ifdef RESULT_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;
    logic [DATA_W-1:0] w_checksum_nxt;
`endif

    // The watchdog only runs while a run is pending or in progress; it stops
    // (saturates) once it reaches its limit because the FSM leaves those states.
    assign w_counting = (r_state == S_IDLE) || (r_state == S_FETCH) || (r_state == S_SEND);
    assign w_expire   = w_counting && (r_cnt == CNT_LAST);
    assign w_accept   = r_valid && bus.out_ready;
    assign w_final    = w_accept && r_last;

    // Next-state and datapath decisions; final handshake outranks the watchdog.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        w_data_nxt     = r_data;
        w_valid_nxt    = r_valid;
        w_last_nxt     = r_last;
        w_finished_nxt = r_finished;
        w_timeout_nxt  = r_timeout;
`ifdef RESULT_CHECKSUM_EN
        w_checksum_nxt = r_checksum;
`endif

        if (w_counting && !w_expire) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_expire) begin
                    w_state_nxt   = S_TIMEOUT;
                    w_timeout_nxt = 1'b1;
                end else if (done) begin
                    w_state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                if (w_expire) begin
                    w_state_nxt   = S_TIMEOUT;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_data_nxt  = bus.regData;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (r_idx == LAST_IDX);
                    w_state_nxt = S_SEND;
                end
            end

            S_SEND: begin
                if (w_final) begin
                    w_valid_nxt    = 1'b0;
                    w_last_nxt     = 1'b0;
                    w_finished_nxt = 1'b1;
                    w_state_nxt    = S_FINISH;
`ifdef RESULT_CHECKSUM_EN
                    w_checksum_nxt = r_checksum + r_data;
`endif
                end else if (w_expire) begin
                    // Pending word is dropped, accepted or not.
                    w_valid_nxt   = 1'b0;
                    w_last_nxt    = 1'b0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_TIMEOUT;
                end else if (w_accept) begin
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_idx_nxt   = r_idx + 1'b1;
                    w_state_nxt = S_FETCH;
`ifdef RESULT_CHECKSUM_EN
                    w_checksum_nxt = r_checksum + r_data;
`endif
                end
            end

            S_FINISH: begin
                if (start) begin
                    w_state_nxt    = S_IDLE;
                    w_idx_nxt      = '0;
                    w_cnt_nxt      = '0;
                    w_finished_nxt = 1'b0;
`ifdef RESULT_CHECKSUM_EN
                    w_checksum_nxt = '0;
`endif
                end
            end

            S_TIMEOUT: begin
                if (start) begin
                    w_state_nxt   = S_IDLE;
                    w_idx_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b0;
`ifdef RESULT_CHECKSUM_EN
                    w_checksum_nxt = '0;
`endif
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_finished <= 1'b0;
            r_timeout  <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
            r_checksum <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_last     <= w_last_nxt;
            r_finished <= w_finished_nxt;
            r_timeout  <= w_timeout_nxt;
`ifdef RESULT_CHECKSUM_EN
            r_checksum <= w_checksum_nxt;
`endif
        end
    end

    assign bus.regAddr   = ADDR_W'(r_idx);
    assign bus.out_data  = r_data;
    assign bus.out_valid = r_valid;
    assign bus.out_last  = r_last;
    assign busy          = (r_state == S_FETCH) || (r_state == S_SEND);
    assign finished      = r_finished;
    assign timeout       = r_timeout;
`ifdef RESULT_CHECKSUM_EN
    assign checksum      = r_checksum;
`endif

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed bench for fft_result_reader with a transaction-level model that
// is compared against the DUT every cycle, plus hand-computed expectations.
`timescale 1ns/1ps
module tb_fft_result_reader;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int NW = 4;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic done;
    logic busy;
    logic finished;
    logic timeout;
`ifdef RESULT_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    fft_result_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    logic [DW-1:0] core_mem [NW];
    assign bus.regData = core_mem[bus.regAddr[1:0]];

    fft_result_reader #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .done     (done),
        .bus      (bus),
        .busy     (busy),
        .finished (finished),
        .timeout  (timeout)
`ifdef RESULT_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, got, want, $time);
        end
    endtask

    // ---------------- model and logs ----------------
    // phase: 0 waiting for done, 1 run in progress, 2 finished, 3 timed out
    int            cyc = 0;
    bit            m_known = 1'b0;
    int            m_phase = 0;
    int            m_cnt = 0;
    int            m_idx = 0;
    bit            m_valid = 1'b0;
    bit            m_expire;
    bit            m_acc;
    logic [DW-1:0] m_sum = '0;

    logic [DW-1:0] beat_q [$];
    int            beat_cyc_q [$];
    int            addr_q [$];
    bit            last_q [$];
    int            stall_cnt = 0;
    int            fin_cyc = -1;
    int            first_valid_cyc = -1;
    int            done_cyc = -1;

    always @(negedge clk) begin
        cyc++;
        if (m_known) begin
            chk("m_busy", busy, m_phase == 1);
            chk("m_valid", bus.out_valid, m_valid);
            chk("m_finished", finished, m_phase == 2);
            chk("m_timeout", timeout, m_phase == 3);
            chk("m_regAddr", bus.regAddr, m_idx);
            if (m_valid) begin
                chk("m_data", bus.out_data, core_mem[m_idx]);
                chk("m_last", bus.out_last, m_idx == NW - 1);
            end else begin
                chk("m_last_idle", bus.out_last, 0);
            end
`ifdef RESULT_CHECKSUM_EN
            chk("m_checksum", checksum, m_sum);
`endif
        end

        if (!reset && bus.out_valid && bus.out_ready) begin
            beat_q.push_back(bus.out_data);
            beat_cyc_q.push_back(cyc);
            addr_q.push_back(int'(bus.regAddr));
            last_q.push_back(bus.out_last);
        end
        if (!reset && bus.out_valid && !bus.out_ready && bus.out_data == 8'd20) stall_cnt++;
        if (finished && fin_cyc < 0) fin_cyc = cyc;
        if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (!reset && m_known && m_phase == 0 && done && done_cyc < 0) done_cyc = cyc;

        if (reset) begin
            m_known = 1'b1;
            m_phase = 0;
            m_cnt   = 0;
            m_idx   = 0;
            m_valid = 1'b0;
            m_sum   = '0;
        end else if (m_known) begin
            m_expire = (m_phase <= 1) && (m_cnt == TO - 1);
            m_acc    = m_valid && bus.out_ready;
            if (m_phase <= 1 && !m_expire) m_cnt++;
            case (m_phase)
                0: begin
                    if (m_expire) m_phase = 3;
                    else if (done) m_phase = 1;
                end
                1: begin
                    if (m_acc && m_idx == NW - 1) begin
                        m_sum   = m_sum + core_mem[m_idx];
                        m_valid = 1'b0;
                        m_phase = 2;
                    end else if (m_expire) begin
                        m_valid = 1'b0;
                        m_phase = 3;
                    end else if (m_acc) begin
                        m_sum   = m_sum + core_mem[m_idx];
                        m_valid = 1'b0;
                        m_idx++;
                    end else if (!m_valid) begin
                        m_valid = 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        m_phase = 0;
                        m_idx   = 0;
                        m_cnt   = 0;
                        m_sum   = '0;
                    end
                end
            endcase
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        beat_q.delete();
        beat_cyc_q.delete();
        addr_q.delete();
        last_q.delete();
        stall_cnt       = 0;
        fin_cyc         = -1;
        first_valid_cyc = -1;
        done_cyc        = -1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        start         = 1'b0;
        done          = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_fin(input string nm, input int bound);
        int g = 0;
        while (!finished && g < bound) begin
            tick();
            g++;
        end
        chk(nm, finished, 1);
        tick();
    endtask

    task automatic check_beats(input string nm, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                               input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        logic [DW-1:0] want [4];
        want = '{w0, w1, w2, w3};
        chk({nm, "_count"}, beat_q.size(), 4);
        if (beat_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk({nm, "_data"}, beat_q[i], want[i]);
                chk({nm, "_addr"}, addr_q[i], i);
                chk({nm, "_last"}, last_q[i], i == 3);
            end
        end
    endtask

    initial begin
        int g;
        int e;
        reset         = 1'b1;
        start         = 1'b0;
        done          = 1'b0;
        bus.out_ready = 1'b1;
        core_mem      = '{8'd10, 8'd20, 8'd30, 8'd40};

        // reset state
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_finished", finished, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_regAddr", bus.regAddr, 0);
        chk("rst_data", bus.out_data, 0);
`ifdef RESULT_CHECKSUM_EN
        chk("rst_checksum", checksum, 0);
`endif

        // plain readout, done at cycle 5, sink always ready
        repeat (5) tick();
        done = 1'b1;
        wait_fin("A_finish", 40);
        check_beats("A", 8'd10, 8'd20, 8'd30, 8'd40);
        if (beat_cyc_q.size() == 4) begin
            for (int i = 0; i < 3; i++) chk("A_gap", beat_cyc_q[i+1] - beat_cyc_q[i], 2);
            chk("A_fin_latency", fin_cyc - beat_cyc_q[3], 1);
        end
        chk("A_first_valid_latency", first_valid_cyc - done_cyc, 2);

        // backpressure on word 20
        do_reset();
        done = 1'b1;
        g = 0;
        while (beat_q.size() < 1 && g < 40) begin
            tick();
            g++;
        end
        chk("B_first_beat", beat_q.size() >= 1, 1);
        bus.out_ready = 1'b0;
        repeat (4) tick();
        bus.out_ready = 1'b1;
        wait_fin("B_finish", 40);
        check_beats("B", 8'd10, 8'd20, 8'd30, 8'd40);
        chk("B_stall_cycles", stall_cnt, 3);

        // watchdog: done never asserted
        do_reset();
        repeat (TO - 1) tick();
        chk("C_timeout_early", timeout, 0);
        tick();
        chk("C_timeout_edge", timeout, 1);
        chk("C_valid", bus.out_valid, 0);
        chk("C_finished", finished, 0);
        chk("C_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("C_rearm_timeout", timeout, 0);
        chk("C_rearm_busy", busy, 0);
        chk("C_rearm_addr", bus.regAddr, 0);
        done = 1'b1;
        wait_fin("C_finish_after_rearm", 40);
        check_beats("C", 8'd10, 8'd20, 8'd30, 8'd40);

        // reset while word 30 is on offer
        do_reset();
        done = 1'b1;
        g = 0;
        while (!(bus.out_valid && bus.out_data == 8'd30) && g < 40) begin
            tick();
            g++;
        end
        chk("D_reached_30", bus.out_valid && bus.out_data == 8'd30, 1);
        reset = 1'b1;
        done  = 1'b0;
        tick();
        reset = 1'b0;
        chk("D_busy", busy, 0);
        chk("D_valid", bus.out_valid, 0);
        chk("D_last", bus.out_last, 0);
        chk("D_data", bus.out_data, 0);
        chk("D_finished", finished, 0);
        chk("D_timeout", timeout, 0);
        chk("D_regAddr", bus.regAddr, 0);
        clear_logs();
        done = 1'b1;
        wait_fin("D_finish", 40);
        check_beats("D", 8'd10, 8'd20, 8'd30, 8'd40);

        // single-cycle done pulse
        do_reset();
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_fin("E_finish", 40);
        check_beats("E", 8'd10, 8'd20, 8'd30, 8'd40);

        // final handshake on the watchdog's last edge: finish wins
        do_reset();
        done = 1'b1;
        e = 0;
        while (e < TO - 1) begin
            tick();
            e++;
            if (beat_q.size() >= 3) bus.out_ready = 1'b0;
        end
        chk("F_pending_last", bus.out_valid && bus.out_last, 1);
        bus.out_ready = 1'b1;
        tick();
        chk("F_tie_finished", finished, 1);
        chk("F_tie_timeout", timeout, 0);

        // one edge too late: watchdog wins and drops the word
        do_reset();
        done = 1'b1;
        e = 0;
        while (e < TO) begin
            tick();
            e++;
            if (beat_q.size() >= 3) bus.out_ready = 1'b0;
        end
        chk("G_timeout", timeout, 1);
        chk("G_finished", finished, 0);
        chk("G_valid", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        tick();
        chk("G_still_finished0", finished, 0);
        chk("G_beats", beat_q.size(), 3);

        // modular checksum data set
        core_mem = '{8'd200, 8'd100, 8'd1, 8'd2};
        do_reset();
        done = 1'b1;
        wait_fin("H_finish", 40);
        check_beats("H", 8'd200, 8'd100, 8'd1, 8'd2);
`ifdef RESULT_CHECKSUM_EN
        chk("H_checksum", checksum, 47);
`endif
        done  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("H_rearm_finished", finished, 0);
`ifdef RESULT_CHECKSUM_EN
        chk("H_rearm_checksum", checksum, 0);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL global_time_limit reached at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_result_reader.md
Name: fft_result_reader

Overview:
- Synthesizable readback sequencer for the RNS Fourier cores (fourier_top_64 and wider successors).
- Waits for the core's done, then walks the core's result register port (regAddr/regData) over NUM_WORDS addresses. Streams each word out on a valid/ready interface with a last marker.
- Includes a cycle watchdog that flags a core that never finishes.
- Replaces ad-hoc bench-side address stepping; usable both in silicon (to a UART/DMA) and in simulation.

Parameters:
- DATA_W, 32: width of regData and out_data.
- ADDR_W, 32: width of regAddr.
- NUM_WORDS, 64: number of result words read per run; must be ≥1 and ≤2^ADDR_W.
- TIMEOUT_CYCLES, 3000: watchdog limit in clk cycles; must be ≥2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; re-arms from FINISH or TIMEOUT. Ignored in other states.
- done  in  1  core completion flag; sampled only in IDLE.
- regAddr  out  ADDR_W  result register address to core.
- regData  in  DATA_W  result word from core; combinational read of regAddr.
- out_data  out  DATA_W  streamed result word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts the word.
- out_last  out  1  high with out_valid on word NUM_WORDS-1.
- busy  out  1  high in FETCH or SEND.
- finished  out  1  sticky; all words delivered.
- timeout  out  1  sticky; watchdog expired.

Behaviour:
- Reset: synchronous, active-high. Takes priority over every other input in the same cycle, including mid-stream. All outputs go to 0; state goes to IDLE; idx=0; cycle counter=0.
- Address: regAddr = idx, zero-extended to ADDR_W. idx width is $clog2(NUM_WORDS), minimum 1.
- States:
  - IDLE: done=1 → FETCH.
  - FETCH, one cycle: regAddr=idx. At the edge, out_data<=regData, out_valid<=1, out_last<=(idx==NUM_WORDS-1). Next state SEND.
  - SEND:
    - out_data, out_valid and out_last hold stable while out_ready=0.
    - On out_valid&&out_ready: out_valid<=0 and out_last<=0.
    - If it was the last word: finished<=1 and go to FINISH.
    - Otherwise idx<=idx+1 and go to FETCH.
  - FINISH: hold. start → IDLE, with idx=0, counter=0, finished<=0.
  - TIMEOUT: out_valid=0 and busy=0. start → IDLE, with idx=0, counter=0, timeout<=0.
- Throughput: one word per 2 cycles maximum. First out_valid appears 2 cycles after done is sampled high in IDLE.
- done is ignored outside IDLE. Deassertion of done mid-stream has no effect.
- Watchdog:
  - Counter increments every non-reset cycle in IDLE, FETCH and SEND.
  - When counter==TIMEOUT_CYCLES-1 at an edge: timeout<=1, state<=TIMEOUT, and any pending word is dropped.
  - Result: timeout rises exactly TIMEOUT_CYCLES edges after reset release.
  - The counter saturates and never wraps.
- Simultaneous events:
  - Final handshake and watchdog expiry at the same edge: FINISH wins, timeout stays 0.
  - start and reset together: reset wins.
- idx wraps never; NUM_WORDS=1 yields a single beat with out_last=1.

Optional Feature:
- Macro: RESULT_CHECKSUM_EN.
- With the macro defined:
  - Extra output checksum [DATA_W-1:0], reset 0.
  - checksum <= checksum + out_data, mod 2^DATA_W, on every accepted beat.
  - Cleared on reset and on start re-arm.
  - Value is final when finished rises.
- Without the macro: port and adder are absent; all other behaviour is identical.

Test Plan:
- Result data: NUM_WORDS=4; core regs = 10, 20, 30, 40; done at cycle 5; out_ready=1 → beats 10, 20, 30, 40 on alternate cycles; out_last only with 40; finished=1 the cycle after; regAddr sequence 0,1,2,3.
- Backpressure: same setup with out_ready low for 3 cycles on word 20 → out_data=20 and out_valid stay stable for those 3 cycles; no skip or duplicate; still 4 beats.
- Watchdog: TIMEOUT_CYCLES=100, done never asserted → timeout=1 exactly 100 edges after reset release; out_valid=0; finished=0. Then pulse start → timeout=0, state IDLE.
- Reset mid-stream: reset pulsed during SEND of word 30 → next cycle all outputs 0, regAddr=0. A later done replays from word 10.
- Done glitch and tie-break: done high 1 cycle then low → full 4-word stream still completes. Separately, place the final handshake on edge TIMEOUT_CYCLES-1 → finished=1, timeout=0.
- Checksum, RESULT_CHECKSUM_EN defined, DATA_W=8: words 200, 100, 1, 2 → checksum=47.
